// File: rtl/kgp_mem_pkg.sv
// ---------------------------------------------------------------------------
// kgp_mem_pkg
//
// Shared types and constants for the KGP-RISC unified memory arbiter.
//
// Contents:
//   DEFAULT_AW / DEFAULT_DW : default word-address and data widths
//   arb_state_t             : arbiter FSM states (IDLE, ISSUE, WAIT, ACK)
//   req_id_t                : identity of a requester (REQ_I fetch, REQ_D data)
//   other_port()            : returns the requester that is not the argument
//
// Build option: KGP_ARB_RR_EN selects round-robin arbitration in kgp_arb_pick
// instead of fixed priority with the instruction-port starvation counter.
// ---------------------------------------------------------------------------
package kgp_mem_pkg;

    localparam int DEFAULT_AW = 32;
    localparam int DEFAULT_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    // The round-robin picker grants the port that was not granted last,
    // so it needs a cheap way to flip a requester identity.
    function automatic req_id_t other_port(input req_id_t id);
        return (id == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/kgp_arb_pick.sv
// ---------------------------------------------------------------------------
// kgp_arb_pick
//
// Purely combinational winner selection between the instruction-fetch port
// (I) and the load/store port (D) of the KGP-RISC memory arbiter.
//
// Default build (KGP_ARB_RR_EN undefined): fixed priority, D beats I unless
// the instruction port has lost STARVE_LIMIT consecutive arbitrations, in
// which case I is forced to win.
//
// KGP_ARB_RR_EN defined: round-robin, on contention the port that was not
// granted last wins. The starvation inputs do not exist in that build.
//
// Ports:
//   i_req       in   fetch port is requesting
//   d_req       in   data port is requesting
//   starve_cnt  in   consecutive I losses (fixed-priority build only)
//   last_grant  in   port granted most recently (round-robin build only)
//   grant_id    out  selected requester
//   grant_valid out  at least one requester is active
// ---------------------------------------------------------------------------
`ifdef KGP_ARB_RR_EN
module kgp_arb_pick
    import kgp_mem_pkg::*;
(
    input  logic    i_req,
    input  logic    d_req,
    input  req_id_t last_grant,
    output req_id_t grant_id,
    output logic    grant_valid
);

    // Round-robin choice: a lone requester always wins; when both request,
    // the one that did not get the previous grant goes first.
    always_comb begin
        grant_valid = i_req | d_req;
        grant_id    = REQ_D;
        if (i_req && d_req) begin
            grant_id = other_port(last_grant);
        end else if (i_req) begin
            grant_id = REQ_I;
        end
    end

endmodule
`else
module kgp_arb_pick
    import kgp_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int SCW          = 3
) (
    input  logic           i_req,
    input  logic           d_req,
    input  logic [SCW-1:0] starve_cnt,
    output req_id_t        grant_id,
    output logic           grant_valid
);

    // Fixed priority with an escape hatch: data accesses normally win so
    // loads and stores are not stalled behind fetches, but once the fetch
    // port has been passed over STARVE_LIMIT times in a row it gets the slot.
    always_comb begin
        grant_valid = i_req | d_req;
        grant_id    = REQ_D;
        if (i_req && !d_req) begin
            grant_id = REQ_I;
        end else if (i_req && d_req && (starve_cnt == SCW'(STARVE_LIMIT))) begin
            grant_id = REQ_I;
        end
    end

endmodule
`endif

// File: rtl/kgp_mem_arbiter.sv
// ---------------------------------------------------------------------------
// kgp_mem_arbiter
//
// Shares one single-port synchronous memory between the KGP-RISC fetch port
// (I) and load/store port (D). Each transaction runs IDLE -> ISSUE -> WAIT
// -> ACK -> IDLE (stores skip WAIT). Every output is registered.
//
// Build option: define KGP_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (D over I) with a saturating starvation counter for I.
//
// Parameters:
//   AW           word-address width
//   DW           data width
//   READ_LAT     cycles from mem_en to valid mem_rdata (>= 1)
//   STARVE_LIMIT consecutive I losses after which I is forced to win (>= 1)
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset (0 = reset)
//   i_req/i_addr      fetch request and word address, held until i_ack
//   i_ack/i_rdata     one-cycle completion pulse and fetch data
//   d_req/d_we/d_addr/d_wdata  load/store request, held until d_ack
//   d_ack/d_rdata     one-cycle completion pulse and load data
//   mem_en/mem_we     memory strobe and write enable (one cycle per access)
//   mem_addr/mem_wdata memory address and write data (hold between accesses)
//   mem_rdata         memory read data, valid READ_LAT cycles after mem_en
//   busy              high whenever the arbiter is not IDLE
// ---------------------------------------------------------------------------
module kgp_mem_arbiter
    import kgp_mem_pkg::*;
#(
    parameter int AW           = DEFAULT_AW,
    parameter int DW           = DEFAULT_DW,
    parameter int READ_LAT     = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    localparam int LW  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state;
    req_id_t       lat_id;
    logic          lat_we;
    logic [LW-1:0] lat_cnt;

    req_id_t       grant_id;
    logic          grant_valid;

`ifdef KGP_ARB_RR_EN
    req_id_t       rr_last;

    // Round-robin picker; rr_last remembers who was granted most recently.
    kgp_arb_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_grant  (rr_last),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );
`else
    logic [SCW-1:0] starve_cnt;

    // Fixed-priority picker fed by the fetch-port starvation counter.
    kgp_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SCW          (SCW)
    ) u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .starve_cnt  (starve_cnt),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );
`endif

    // Main FSM. All outputs are registered, so each one is written on the
    // edge that enters the state in which it must be visible: mem_en/mem_we
    // on the edge into ISSUE, the ack pulse on the edge into ACK, busy on
    // the edges into ISSUE and back to IDLE.
    //
    // mem_addr and mem_wdata double as the address/data latch: they are
    // loaded at grant time and simply hold afterwards, which also gives the
    // required "hold last value outside ISSUE" behaviour. A fetch leaves
    // mem_wdata untouched because the fetch port has no write data.
    //
    // The latency counter is loaded with READ_LAT-1 on leaving ISSUE and
    // counts down in WAIT; read data is captured in the WAIT cycle where it
    // reaches zero, which is exactly READ_LAT cycles after mem_en.
    //
    // The arbitration state (starvation counter or round-robin pointer) is
    // only touched in IDLE with a valid grant, so requests that move around
    // while a transaction is in flight have no effect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat_id     <= REQ_I;
            lat_we     <= 1'b0;
            lat_cnt    <= '0;
            i_ack      <= 1'b0;
            i_rdata    <= '0;
            d_ack      <= 1'b0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
`ifdef KGP_ARB_RR_EN
            rr_last    <= REQ_I;
`else
            starve_cnt <= '0;
`endif
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            i_ack  <= 1'b0;
            d_ack  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        lat_id <= grant_id;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        state  <= ISSUE;
                        if (grant_id == REQ_D) begin
                            lat_we    <= d_we;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            lat_we    <= 1'b0;
                            mem_addr  <= i_addr;
                        end
`ifdef KGP_ARB_RR_EN
                        rr_last <= grant_id;
`else
                        if (grant_id == REQ_I) begin
                            starve_cnt <= '0;
                        end else if (i_req && (starve_cnt != SCW'(STARVE_LIMIT))) begin
                            starve_cnt <= starve_cnt + SCW'(1);
                        end
`endif
                    end
                end

                ISSUE: begin
                    if (lat_we) begin
                        d_ack <= 1'b1;
                        state <= ACK;
                    end else begin
                        lat_cnt <= LW'(READ_LAT - 1);
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (lat_id == REQ_I) begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end
                        state <= ACK;
                    end else begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end
                end

                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
